// File: rtl/inter_switch_mc.sv
// -----------------------------------------------------------------------------
// inter_switch_mc
//   Parametrised N_IN x N_OUT AXI-Stream packet switch. A route (one input,
//   one or more outputs) is taken through a cfg handshake. It stays locked
//   until the tlast beat has been delivered to every selected output, so a
//   packet is never switched part-way through. Data passes through one shared
//   output register. With every selected output ready, the switch moves one
//   beat per cycle.
//
//   Optional feature macro: INTER_SWITCH_MCAST_EN
//     defined   : multicast. Each output in the mask receives every beat
//                 exactly once; a done[] vector tracks which outputs have
//                 already taken the current beat.
//     undefined : unicast. The latched mask is the lowest set bit of
//                 cfg_out_mask. cfg_err rules are the same in both builds.
//
// Handshake rule, used on every port: a transfer happens on a rising clk edge
// where valid & ready are both 1. A source keeps valid high and its payload
// stable until that edge. Ready may depend combinationally on the switch state.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_in_sel      input index for the next packet
//   cfg_out_mask    destination outputs, one bit per output
//   cfg_valid/ready route request handshake (ready only in IDLE)
//   cfg_err         1-cycle pulse: illegal route request dropped
//   s_tdata/tvalid/tlast/tready   N_IN input streams, input i at [i*DATA_W +: DATA_W]
//   m_tdata/tlast   shared registered output payload
//   m_tvalid/tready per-output handshake
//   busy            1 while a route is locked
//   pkt_cnt         completed packets, wraps
//   dbg_state       FSM state (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module inter_switch_mc #(
    parameter int DATA_W = 1536,
    parameter int N_IN   = 5,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = $clog2(N_IN),
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SEL_W-1:0]       cfg_in_sel,
    input  logic [N_OUT-1:0]       cfg_out_mask,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   cfg_err,
    input  logic [N_IN*DATA_W-1:0] s_tdata,
    input  logic [N_IN-1:0]        s_tvalid,
    input  logic [N_IN-1:0]        s_tlast,
    output logic [N_IN-1:0]        s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tlast,
    output logic [N_OUT-1:0]       m_tvalid,
    input  logic [N_OUT-1:0]       m_tready,
    output logic                   busy,
    output logic [CNT_W-1:0]       pkt_cnt,
    output logic                   dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [SEL_W:0] N_IN_L  = N_IN[SEL_W:0];
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e              state_q;
    logic [SEL_W-1:0]    sel_q;
    logic [N_OUT-1:0]    mask_q;
    logic                ovld_q;
    logic [DATA_W-1:0]   data_q;
    logic                last_q;
    logic                tlast_taken_q;
    logic [CNT_W-1:0]    pkt_cnt_q;
    logic                cfg_err_q;

    logic [N_OUT-1:0]    mvalid;
    logic [N_OUT-1:0]    mask_d;
    logic                beat_done;
    logic                adv;
    logic                accept;
    logic                cfg_bad;
    logic [N_IN-1:0]     sready;
    logic [DATA_W-1:0]   in_data;
    logic                in_last;

`ifdef INTER_SWITCH_MCAST_EN
    logic [N_OUT-1:0]    done_q;
    logic [N_OUT-1:0]    fire;

    // An output that has already taken the current beat is masked off until
    // every selected output has taken it.
    assign mvalid    = {N_OUT{ovld_q}} & mask_q & ~done_q;
    assign fire      = mvalid & m_tready;
    assign beat_done = ovld_q & (((done_q | fire) & mask_q) == mask_q);
    assign mask_d    = cfg_out_mask;
`else
    localparam logic [N_OUT-1:0] MASK_ONE = {{(N_OUT-1){1'b0}}, 1'b1};

    // Unicast: the mask holds exactly one bit, so the beat is complete as soon
    // as that one output is ready.
    assign mvalid    = {N_OUT{ovld_q}} & mask_q;
    assign beat_done = ovld_q & (|(m_tready & mask_q));
    // Two's-complement trick: keeps only the lowest set bit.
    assign mask_d    = cfg_out_mask & (~cfg_out_mask + MASK_ONE);
`endif

    // The output register can take a new beat when it is empty, or when its
    // current beat is finishing this cycle.
    assign adv     = ~ovld_q | beat_done;
    assign cfg_bad = ({1'b0, cfg_in_sel} >= N_IN_L) || (cfg_out_mask == '0);

    always_comb begin
        sready = '0;
        if (state_q == S_RUN && adv && !tlast_taken_q) begin
            sready[sel_q] = 1'b1;
        end
    end

    // Input mux with constant slice indices; inputs that are not selected
    // never reach the register.
    always_comb begin
        in_data = '0;
        in_last = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel_q == i[SEL_W-1:0]) begin
                in_data = s_tdata[i*DATA_W +: DATA_W];
                in_last = s_tlast[i];
            end
        end
    end

    // sready is one-hot at sel_q, so this is s_tvalid[sel_q] & s_tready[sel_q].
    assign accept = |(s_tvalid & sready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            mask_q        <= '0;
            ovld_q        <= 1'b0;
            data_q        <= '0;
            last_q        <= 1'b0;
            tlast_taken_q <= 1'b0;
            pkt_cnt_q     <= '0;
            cfg_err_q     <= 1'b0;
`ifdef INTER_SWITCH_MCAST_EN
            done_q        <= '0;
`endif
        end else begin
            cfg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            sel_q   <= cfg_in_sel;
                            mask_q  <= mask_d;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
`ifdef INTER_SWITCH_MCAST_EN
                    done_q <= beat_done ? '0 : (done_q | fire);
`endif
                    if (accept) begin
                        data_q <= in_data;
                        last_q <= in_last;
                        ovld_q <= 1'b1;
                        if (in_last) begin
                            tlast_taken_q <= 1'b1;
                        end
                    end else if (beat_done) begin
                        ovld_q <= 1'b0;
                    end
                    // No input is accepted once tlast has been taken, so the
                    // register is empty after the last beat leaves.
                    if (beat_done && last_q) begin
                        state_q       <= S_IDLE;
                        pkt_cnt_q     <= pkt_cnt_q + CNT_ONE;
                        tlast_taken_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign dbg_state = state_q;
    assign cfg_err   = cfg_err_q;
    assign s_tready  = sready;
    assign m_tdata   = data_q;
    assign m_tlast   = last_q;
    assign m_tvalid  = mvalid;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_inter_switch_mc.sv
module tb_inter_switch_mc;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [2:0]    cfg_in_sel;
  logic [7:0]    cfg_out_mask;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_err;
  logic [5*DW-1:0] s_tdata;
  logic [4:0]    s_tvalid;
  logic [4:0]    s_tlast;
  logic [4:0]    s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [7:0]    m_tvalid;
  logic [7:0]    m_tready;
  logic          busy;
  logic [15:0]   pkt_cnt;
  logic          dbg_state;

  inter_switch_mc #(.DATA_W(DW), .N_IN(5), .N_OUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_in_sel(cfg_in_sel), .cfg_out_mask(cfg_out_mask),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy), .pkt_cnt(pkt_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [DW-1:0] exp_q[$];
  int rx_cnt[8];
  int data_err, stray_rdy, stray_vld, cfgrdy_bad, stall_bad, cycles;
  logic first_mv;

  // ---------------- driver tasks ----------------
  // All drivers are entered and left at posedge+1.
  task automatic do_cfg(input logic [2:0] sel, input logic [7:0] mask);
    cfg_in_sel   = sel;
    cfg_out_mask = mask;
    cfg_valid    = 1'b1;
    @(posedge clk); #1;
    cfg_valid    = 1'b0;
  endtask

  // Drives an n-beat packet on input sel and records what every output
  // receives. mode 0: all outputs ready; mode 1: out2 ready every 3rd cycle.
  task automatic run_packet(input int sel, input int n, input logic [DW-1:0] base,
                            input logic [7:0] dest, input int mode, input bit noise);
    logic [DW-1:0] prev_data;
    logic [7:0]    prev_pending;
    int idx;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + DW'(i));
    foreach (rx_cnt[j]) rx_cnt[j] = 0;
    data_err = 0; stray_rdy = 0; stray_vld = 0; cfgrdy_bad = 0; stall_bad = 0; cycles = 0;
    idx = 0; prev_pending = '0; prev_data = '0;
    for (int c = 0; c < 200; c++) begin
      s_tvalid = noise ? 5'b01010 : 5'b00000;
      s_tlast  = noise ? 5'b01010 : 5'b00000;
      if (noise) begin
        s_tdata[1*DW +: DW] = $urandom;
        s_tdata[3*DW +: DW] = $urandom;
      end
      if (idx < n) begin
        s_tvalid[sel] = 1'b1;
        s_tlast[sel]  = (idx == n - 1);
        s_tdata[sel*DW +: DW] = exp_q[idx];
      end
      m_tready = (mode == 0) ? 8'hFF : (8'hFB | ((c % 3 == 2) ? 8'h04 : 8'h00));
      @(negedge clk);
      if (c == 0) first_mv = |m_tvalid;
      cycles++;
      if ((s_tready & ~(5'b00001 << sel)) != 5'b0) stray_rdy++;
      if (cfg_ready) cfgrdy_bad++;
      if ((m_tvalid & ~dest) != 8'h00) stray_vld++;
      if (prev_pending != 8'h00 && ((prev_pending & ~m_tvalid) != 8'h00 || m_tdata !== prev_data))
        stall_bad++;
      for (int j = 0; j < 8; j++) begin
        if (m_tvalid[j] && m_tready[j]) begin
          if (rx_cnt[j] >= n || m_tdata !== exp_q[rx_cnt[j]] || m_tlast !== (rx_cnt[j] == n - 1))
            data_err++;
          rx_cnt[j]++;
        end
      end
      prev_pending = m_tvalid & ~m_tready;
      prev_data    = m_tdata;
      if (s_tvalid[sel] && s_tready[sel]) idx++;
      @(posedge clk); #1;
      if (!busy) break;
    end
    s_tvalid = '0;
    s_tlast  = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_in_sel = '0; cfg_out_mask = '0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); else n_pass++;
    n_total++; if (s_tready !== 5'b0) $display("FAIL reset_s_tready got=%b exp=0", s_tready); else n_pass++;
    n_total++; if (m_tvalid !== 8'h00) $display("FAIL reset_m_tvalid got=%h exp=00", m_tvalid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd0) $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); else n_pass++;
    n_total++; if (m_tdata !== '0 || m_tlast !== 1'b0) $display("FAIL reset_m_data got=%h/%b exp=0/0", m_tdata, m_tlast); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_cfg(3'd2, 8'h01);
    run_packet(2, 4, 32'hA000_0000, 8'h01, 0, 1'b0);
    n_total++; if (first_mv !== 1'b0) $display("FAIL single_latency got=%b exp=0", first_mv); else n_pass++;
    n_total++; if (cycles != 5) $display("FAIL single_cycles got=%0d exp=5", cycles); else n_pass++;
    n_total++; if (rx_cnt[0] != 4) $display("FAIL single_rx0 got=%0d exp=4", rx_cnt[0]); else n_pass++;
    n_total++; if (data_err != 0) $display("FAIL single_data got=%0d exp=0", data_err); else n_pass++;
    n_total++; if (stray_vld != 0) $display("FAIL single_stray_vld got=%0d exp=0", stray_vld); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd1) $display("FAIL single_pkt_cnt got=%0d exp=1", pkt_cnt); else n_pass++;
  endtask

  task automatic test_multicast();
    logic [7:0] dest;
    int exp_rx2;
`ifdef INTER_SWITCH_MCAST_EN
    dest = 8'h06; exp_rx2 = 4;
`else
    dest = 8'h02; exp_rx2 = 0;
`endif
    do_cfg(3'd0, 8'h06);
    run_packet(0, 4, 32'h1234_0000, dest, 1, 1'b0);
    n_total++; if (rx_cnt[1] != 4) $display("FAIL mc_rx1 got=%0d exp=4", rx_cnt[1]); else n_pass++;
    n_total++; if (rx_cnt[2] != exp_rx2) $display("FAIL mc_rx2 got=%0d exp=%0d", rx_cnt[2], exp_rx2); else n_pass++;
    n_total++; if (data_err != 0) $display("FAIL mc_data got=%0d exp=0", data_err); else n_pass++;
    n_total++; if (stall_bad != 0) $display("FAIL mc_stall got=%0d exp=0", stall_bad); else n_pass++;
    n_total++; if (stray_vld != 0) $display("FAIL mc_stray_vld got=%0d exp=0", stray_vld); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd2) $display("FAIL mc_pkt_cnt got=%0d exp=2", pkt_cnt); else n_pass++;
  endtask

  task automatic test_unicast_lowest();
    logic [7:0] dest;
    int exp_rx3;
`ifdef INTER_SWITCH_MCAST_EN
    dest = 8'h0C; exp_rx3 = 3;
`else
    dest = 8'h04; exp_rx3 = 0;
`endif
    do_cfg(3'd1, 8'h0C);
    run_packet(1, 3, 32'h5500_0010, dest, 0, 1'b0);
    n_total++; if (rx_cnt[2] != 3) $display("FAIL uc_rx2 got=%0d exp=3", rx_cnt[2]); else n_pass++;
    n_total++; if (rx_cnt[3] != exp_rx3) $display("FAIL uc_rx3 got=%0d exp=%0d", rx_cnt[3], exp_rx3); else n_pass++;
    n_total++; if (stray_vld != 0) $display("FAIL uc_stray_vld got=%0d exp=0", stray_vld); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd3) $display("FAIL uc_pkt_cnt got=%0d exp=3", pkt_cnt); else n_pass++;
  endtask

  task automatic test_ignore();
    do_cfg(3'd0, 8'h01);
    // A second route request is held while the first packet runs.
    cfg_in_sel = 3'd1; cfg_out_mask = 8'h02; cfg_valid = 1'b1;
    run_packet(0, 3, 32'hB000_0000, 8'h01, 0, 1'b1);
    n_total++; if (stray_rdy != 0) $display("FAIL ign_s_tready got=%0d exp=0", stray_rdy); else n_pass++;
    n_total++; if (cfgrdy_bad != 0) $display("FAIL ign_cfg_ready got=%0d exp=0", cfgrdy_bad); else n_pass++;
    n_total++; if (rx_cnt[0] != 3 || data_err != 0) $display("FAIL ign_rx0 got=%0d/%0d exp=3/0", rx_cnt[0], data_err); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd4) $display("FAIL ign_pkt_cnt got=%0d exp=4", pkt_cnt); else n_pass++;
    @(negedge clk);
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL ign_cfg_ready_idle got=%b exp=1", cfg_ready); else n_pass++;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b1 || s_tready !== 5'b00010) $display("FAIL ign_held_cfg got=%b/%b exp=1/00010", busy, s_tready); else n_pass++;
    @(posedge clk); #1;
    run_packet(1, 2, 32'hC000_0000, 8'h02, 0, 1'b0);
    n_total++; if (rx_cnt[1] != 2 || data_err != 0) $display("FAIL ign_held_rx1 got=%0d/%0d exp=2/0", rx_cnt[1], data_err); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd5) $display("FAIL ign_held_pkt_cnt got=%0d exp=5", pkt_cnt); else n_pass++;
  endtask

  task automatic test_cfg_err();
    s_tvalid = 5'b11111;
    do_cfg(3'd5, 8'h01);
    @(negedge clk);
    n_total++; if (cfg_err !== 1'b1) $display("FAIL err_sel_pulse got=%b exp=1", cfg_err); else n_pass++;
    n_total++; if (busy !== 1'b0 || s_tready !== 5'b0) $display("FAIL err_sel_idle got=%b/%b exp=0/00000", busy, s_tready); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (cfg_err !== 1'b0) $display("FAIL err_pulse_width got=%b exp=0", cfg_err); else n_pass++;
    @(posedge clk); #1;
    do_cfg(3'd1, 8'h00);
    @(negedge clk);
    n_total++; if (cfg_err !== 1'b1) $display("FAIL err_mask_pulse got=%b exp=1", cfg_err); else n_pass++;
    n_total++; if (busy !== 1'b0 || s_tready !== 5'b0) $display("FAIL err_mask_idle got=%b/%b exp=0/00000", busy, s_tready); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd5) $display("FAIL err_pkt_cnt got=%0d exp=5", pkt_cnt); else n_pass++;
    @(posedge clk); #1;
    s_tvalid = '0;
  endtask

  task automatic test_back_to_back();
    do_cfg(3'd3, 8'h10);
    run_packet(3, 1, 32'hD000_0001, 8'h10, 0, 1'b0);
    n_total++; if (rx_cnt[4] != 1 || data_err != 0) $display("FAIL b2b_first got=%0d/%0d exp=1/0", rx_cnt[4], data_err); else n_pass++;
    n_total++; if (cycles != 2) $display("FAIL b2b_cycles got=%0d exp=2", cycles); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd6) $display("FAIL b2b_pkt_cnt1 got=%0d exp=6", pkt_cnt); else n_pass++;
    do_cfg(3'd4, 8'h20);
    run_packet(4, 1, 32'hD000_0002, 8'h20, 0, 1'b0);
    n_total++; if (rx_cnt[5] != 1 || data_err != 0) $display("FAIL b2b_second got=%0d/%0d exp=1/0", rx_cnt[5], data_err); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd7) $display("FAIL b2b_pkt_cnt2 got=%0d exp=7", pkt_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_cfg(3'd3, 8'h01);
    m_tready = 8'h00;
    s_tvalid = 5'b01000; s_tlast = 5'b0;
    s_tdata[3*DW +: DW] = 32'hE000_0000;
    @(posedge clk); #1;
    s_tdata[3*DW +: DW] = 32'hE000_0001;
    @(posedge clk); #1;
    n_total++; if (m_tvalid !== 8'h01 || m_tdata !== 32'hE000_0000) $display("FAIL mid_before got=%h/%h exp=01/e0000000", m_tvalid, m_tdata); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0 || cfg_ready !== 1'b1) $display("FAIL mid_rst_state got=%b/%b exp=0/1", busy, cfg_ready); else n_pass++;
    n_total++; if (m_tvalid !== 8'h00 || s_tready !== 5'b0) $display("FAIL mid_rst_valid got=%h/%b exp=00/00000", m_tvalid, s_tready); else n_pass++;
    n_total++; if (m_tdata !== '0 || pkt_cnt !== 16'd0) $display("FAIL mid_rst_data got=%h/%0d exp=0/0", m_tdata, pkt_cnt); else n_pass++;
    s_tvalid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cfg(3'd4, 8'h80);
    run_packet(4, 3, 32'hF000_0000, 8'h80, 0, 1'b0);
    n_total++; if (rx_cnt[7] != 3 || data_err != 0) $display("FAIL mid_after_rx got=%0d/%0d exp=3/0", rx_cnt[7], data_err); else n_pass++;
    n_total++; if (stray_vld != 0) $display("FAIL mid_after_stray got=%0d exp=0", stray_vld); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd1) $display("FAIL mid_after_pkt_cnt got=%0d exp=1", pkt_cnt); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_multicast();
    test_unicast_lowest();
    test_ignore();
    test_cfg_err();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
